// File: rtl/modstick_regbank_pkg.sv
// Shared definitions for the modstick register bank: register map,
// default constant values and the read-select encoding used by the top.
package modstick_regbank_pkg;

  // Word addresses of the register map
  localparam int unsigned A_ID     = 0;
  localparam int unsigned A_STATUS = 1;
  localparam int unsigned A_IRQEN  = 2;
  localparam int unsigned A_LED    = 3;
  localparam int unsigned A_ERRCNT = 4;
  localparam int unsigned A_MBOX0  = 5;

  // Default constants returned by the ID register and for unmapped reads
  localparam logic [15:0] DEF_ID_VAL  = 16'h1234;
  localparam logic [15:0] DEF_BAD_VAL = 16'hbeef;

  // Which register an address decodes to
  typedef enum logic [2:0] {
    SEL_ID     = 3'd0,
    SEL_STATUS = 3'd1,
    SEL_IRQEN  = 3'd2,
    SEL_LED    = 3'd3,
    SEL_ERRCNT = 3'd4,
    SEL_MBOX   = 3'd5,
    SEL_NONE   = 3'd6
  } reg_sel_e;

  // Index width for an array of n entries (at least one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    idx_width = (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/modstick_regbank_if.sv
// Simple valid/iswrite/ack register bus. The master issues at most one
// access per cycle while valid is high; the slave acks one cycle later.
interface modstick_regbank_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
) ();

  logic          valid;
  logic          iswrite;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (
    output valid, iswrite, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  valid, iswrite, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/modstick_regbank_errtrack.sv
// Error tracking for the register bank: sticky write-1-to-clear STATUS
// flags fed by level error inputs, plus a saturating counter of cycles on
// which at least one error input rose.
module modstick_regbank_errtrack #(
  parameter int unsigned NERR = 4,
  parameter int unsigned DW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NERR-1:0] err_i,
  input  logic [NERR-1:0] w1c_i,
  input  logic            cnt_clr_i,
  output logic [NERR-1:0] status_o,
  output logic [DW-1:0]   errcnt_o
);

  logic [NERR-1:0] status_q,   status_d;
  logic [NERR-1:0] err_prev_q, err_prev_d;
  logic [DW-1:0]   errcnt_q,   errcnt_d;
  logic            rise;

  // Next-state: set beats a same-cycle clear; a clear coinciding with a rise leaves a count of one
  always_comb begin
    rise       = |(err_i & ~err_prev_q);
    status_d   = (status_q & ~w1c_i) | err_i;
    err_prev_d = err_i;
    if (cnt_clr_i) begin
      errcnt_d = DW'(rise);
    end else if (rise && (errcnt_q != {DW{1'b1}})) begin
      errcnt_d = errcnt_q + DW'(1);
    end else begin
      errcnt_d = errcnt_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= '0;
      err_prev_q <= '0;
      errcnt_q   <= '0;
    end else begin
      status_q   <= status_d;
      err_prev_q <= err_prev_d;
      errcnt_q   <= errcnt_d;
    end
  end

  assign status_o = status_q;
  assign errcnt_o = errcnt_q;

endmodule

// File: rtl/modstick_regbank.sv
// modstick register bank: ID word, sticky error STATUS, IRQ enable mask,
// saturating error counter, software LEDs (one LED mirrors "any error")
// and scratch mailboxes, on the simple valid/iswrite/ack bus.
module modstick_regbank
  import modstick_regbank_pkg::*;
#(
  parameter int unsigned   DW      = 16,
  parameter int unsigned   AW      = 16,
  parameter int unsigned   NERR    = 4,
  parameter int unsigned   NLED    = 5,
  parameter int unsigned   ERR_LED = 1,
  parameter int unsigned   NMBOX   = 4,
  parameter logic [DW-1:0] ID_VAL  = DW'(DEF_ID_VAL),
  parameter logic [DW-1:0] BAD_VAL = DW'(DEF_BAD_VAL)
) (
  input  logic                clk,
  input  logic                reset,
  modstick_regbank_if.slave   bus,
  input  logic [NERR-1:0]     err_in,
  output logic                irq,
  output logic [NLED-1:0]     leds
);

  localparam int unsigned MBW = idx_width(NMBOX);
  // Software-writable LED bits; the error LED is owned by hardware
  localparam logic [NLED-1:0] LED_SW_MASK = ~(NLED'(1) << ERR_LED);

  reg_sel_e         sel;
  logic [MBW-1:0]   mbox_idx;
  logic             wr_en;
  logic             rd_en;
  logic [DW-1:0]    rd_val;
  logic [NERR-1:0]  w1c;
  logic             cnt_clr;
  logic [NERR-1:0]  status;
  logic [DW-1:0]    errcnt;

  logic             ack_q,    ack_d;
  logic [DW-1:0]    rdata_q,  rdata_d;
  logic             irq_q,    irq_d;
  logic [NLED-1:0]  leds_q,   leds_d;
  logic [NERR-1:0]  irq_en_q, irq_en_d;
  logic [NLED-1:0]  led_q,    led_d;
  logic [DW-1:0]    mbox_q [NMBOX];
  logic [DW-1:0]    mbox_d [NMBOX];

  // Full-width address decode into a register select and mailbox index
  always_comb begin
    sel      = SEL_NONE;
    mbox_idx = '0;
    if (bus.addr == AW'(A_ID)) begin
      sel = SEL_ID;
    end else if (bus.addr == AW'(A_STATUS)) begin
      sel = SEL_STATUS;
    end else if (bus.addr == AW'(A_IRQEN)) begin
      sel = SEL_IRQEN;
    end else if (bus.addr == AW'(A_LED)) begin
      sel = SEL_LED;
    end else if (bus.addr == AW'(A_ERRCNT)) begin
      sel = SEL_ERRCNT;
    end else begin
      for (int i = 0; i < int'(NMBOX); i++) begin
        if (bus.addr == AW'(int'(A_MBOX0) + i)) begin
          sel      = SEL_MBOX;
          mbox_idx = MBW'(i);
        end else begin
          mbox_idx = mbox_idx;
        end
      end
    end
  end

  // Read mux over the register values as they stand at the start of the cycle
  always_comb begin
    case (sel)
      SEL_ID:     rd_val = ID_VAL;
      SEL_STATUS: rd_val = DW'(status);
      SEL_IRQEN:  rd_val = DW'(irq_en_q);
      SEL_LED:    rd_val = DW'(leds_q);
      SEL_ERRCNT: rd_val = errcnt;
      SEL_MBOX:   rd_val = mbox_q[mbox_idx];
      default:    rd_val = BAD_VAL;
    endcase
  end

  // Write strobes and next-state for the bus-visible registers
  always_comb begin
    wr_en    = bus.valid & bus.iswrite;
    rd_en    = bus.valid & ~bus.iswrite;
    w1c      = (wr_en && (sel == SEL_STATUS)) ? bus.wdata[NERR-1:0] : '0;
    cnt_clr  = wr_en && (sel == SEL_ERRCNT);
    irq_en_d = (wr_en && (sel == SEL_IRQEN)) ? bus.wdata[NERR-1:0] : irq_en_q;
    led_d    = (wr_en && (sel == SEL_LED)) ? (bus.wdata[NLED-1:0] & LED_SW_MASK) : led_q;
    for (int i = 0; i < int'(NMBOX); i++) begin
      if (wr_en && (sel == SEL_MBOX) && (mbox_idx == MBW'(i))) begin
        mbox_d[i] = bus.wdata;
      end else begin
        mbox_d[i] = mbox_q[i];
      end
    end
    ack_d   = bus.valid;
    rdata_d = rd_en ? rd_val : rdata_q;
    // LED and IRQ outputs follow the registers with one cycle of lag
    leds_d  = (led_q & LED_SW_MASK) | (NLED'(|status) << ERR_LED);
    irq_d   = |(status & irq_en_q);
  end

  // Bus-side and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      leds_q   <= '0;
      irq_en_q <= '0;
      led_q    <= '0;
      for (int i = 0; i < int'(NMBOX); i++) begin
        mbox_q[i] <= '0;
      end
    end else begin
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      leds_q   <= leds_d;
      irq_en_q <= irq_en_d;
      led_q    <= led_d;
      for (int i = 0; i < int'(NMBOX); i++) begin
        mbox_q[i] <= mbox_d[i];
      end
    end
  end

  modstick_regbank_errtrack #(
    .NERR (NERR),
    .DW   (DW)
  ) u_errtrack (
    .clk       (clk),
    .reset     (reset),
    .err_i     (err_in),
    .w1c_i     (w1c),
    .cnt_clr_i (cnt_clr),
    .status_o  (status),
    .errcnt_o  (errcnt)
  );

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign irq       = irq_q;
  assign leds      = leds_q;

endmodule
